conv_acc_array: RTL and testbench
=================================

Name: conv_acc_array

Overview:
- Multi-channel, parametrised accumulator for convolution partial products.
- Accumulates a fixed window of TERMS input words per channel, then emits one clamped result per channel through a valid/ready output stage.
- Adds a registered input stage, signed/unsigned mode, optional ReLU, saturation flags and backpressure.
- Sits between the multiplier/adder tree and the feature-map writeback.

Parameters:
- CHANNELS, 4: number of independent accumulator lanes.
- IN_W, 18: width of each input term.
- ACC_W, 24: internal accumulator width; must be at least IN_W+1.
- OUT_W, 19: width of each output result; must not exceed ACC_W.
- TERMS, 9: terms per window; must be at least 2.
- SIGNED, 1: 1 = two's-complement data; 0 = unsigned data.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of the window in progress
- relu_en  in  1  clamp negative results to 0; ignored when SIGNED=0
- in_valid  in  1  input term valid
- in_ready  out  1  block can accept an input term
- in_data  in  CHANNELS*IN_W  packed terms; channel c occupies bits [c*IN_W +: IN_W]
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts the result word
- out_data  out  CHANNELS*OUT_W  packed results, same packing as in_data
- out_sat  out  CHANNELS  per-channel flag: saturation occurred in this window
- term_cnt  out  $clog2(TERMS)  number of terms already added in the current window

Behaviour:
- Reset (rst low), asynchronous: every register clears. out_valid=0, out_data=0, out_sat=0, term_cnt=0, input stage empty, all accumulators 0.
- in_ready = !flush && (!out_valid || out_ready).
- Handshake: a term is accepted on a cycle with in_valid && in_ready.
- Stage 1: an accepted term is registered into in_q, and in_q_valid is set.
- Stage 2: while in_q_valid, each lane computes acc += ext(in_q[c]).
  - ext is sign-extension when SIGNED=1, zero-extension when SIGNED=0.
  - The add saturates at the ACC_W range; a clamp sets that lane's sticky sat bit.
  - term_cnt increments.
  - in_q_valid clears unless a new term is accepted on the same cycle.
- Latency: the last term of a window is accepted in cycle t; out_valid rises at t+2. Sustained throughput is one term per cycle.
- Window completion (stage 2 adds term TERMS-1):
  - Final value = acc + term.
  - If relu_en && SIGNED && final < 0, final = 0.
  - final is clamped to the OUT_W range (signed or unsigned per SIGNED); a clamp also sets the sat bit.
  - out_data and out_sat are loaded, and out_valid is set.
  - acc, sat bits and term_cnt clear on the same edge.
  - TERMS>=2 guarantees that completion never collides with an unaccepted out_valid.
- Output stage:
  - out_valid stays high, and out_data/out_sat stay stable, until out_valid && out_ready.
  - On that cycle out_valid clears, unless a completion occurs on the same edge, in which case the new result loads and out_valid stays 1.
- flush:
  - On the next edge, clears acc, sat bits, term_cnt and in_q_valid.
  - A pending out_valid result is not dropped.
  - flush has priority over acceptance (in_ready is low during flush) and over a same-cycle completion, so no result is produced.
- Reset asserted mid-window or mid-handshake: out_valid drops immediately and the partial window is discarded.
- Lanes never interact.

Decomposition:
- Package conv_acc_pkg holds:
  - saturating-add function;
  - clamp-to-width function;
  - ACC_MAX/ACC_MIN and OUT_MAX/OUT_MIN constants derived from the width and SIGNED parameters.
- One sub-module, conv_acc_lane, generated CHANNELS times. It contains the extension, saturating accumulator, ReLU and output clamp.
- Top level holds in_q, term_cnt, the handshake logic and the output register.

Test Plan:
1. Reset: hold rst low with in_valid=1 -> out_valid=0, in_ready=1 after release, term_cnt=0, out_data=0.
2. Basic window: 9 back-to-back terms per lane, ch0=1000, ch1=-5, ch2=0, ch3=7, relu_en=0 -> out_data = {63, 0, -45, 9000}, out_sat=0, out_valid 2 cycles after the last accept.
3. ReLU: repeat scenario 2 with relu_en=1 -> ch1=0, other lanes unchanged.
4. Saturation:
   - ch0 = 9 x 131071 -> 262143, out_sat[0]=1.
   - ch1 = 9 x -131072 -> -262144, out_sat[1]=1.
   - SIGNED=0 build, ch0 = 9 x 262143 -> 524287, out_sat[0]=1.
5. Backpressure: hold out_ready=0 after a result -> in_ready=0, out_data stable for 20 cycles. Raise out_ready -> one-cycle acceptance, then a second window of 9 x 2 yields 18 on all lanes with no lost or duplicated term.
6. Flush and reset mid-window:
   - Flush after 4 terms of 500, then 9 terms of 10 -> 90 per lane.
   - Drop rst after 5 terms -> immediate out_valid=0, term_cnt=0; the next full window is correct.

Source files
------------

// File: rtl/conv_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_acc_pkg
//  Description : Shared types, range helpers and saturating arithmetic for
//                the convolution partial-product accumulator array.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_acc_pkg;

    // Default build parameters
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_IN_W     = 18;
    localparam int DEF_ACC_W    = 24;
    localparam int DEF_OUT_W    = 19;
    localparam int DEF_TERMS    = 9;
    localparam int DEF_SIGNED   = 1;

    // Value plus a flag telling whether it had to be clamped
    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_res_t;

    // Largest representable value of a field of the given width
    function automatic logic signed [63:0] range_max(input int width, input bit is_signed);
        if (is_signed) begin
            return (64'sd1 <<< (width - 1)) - 64'sd1;
        end
        return (64'sd1 <<< width) - 64'sd1;
    endfunction

    // Smallest representable value of a field of the given width
    function automatic logic signed [63:0] range_min(input int width, input bit is_signed);
        if (is_signed) begin
            return -(64'sd1 <<< (width - 1));
        end
        return 64'sd0;
    endfunction

    // Range constants for the default build
    localparam logic signed [63:0] ACC_MAX = range_max(DEF_ACC_W, DEF_SIGNED != 0);
    localparam logic signed [63:0] ACC_MIN = range_min(DEF_ACC_W, DEF_SIGNED != 0);
    localparam logic signed [63:0] OUT_MAX = range_max(DEF_OUT_W, DEF_SIGNED != 0);
    localparam logic signed [63:0] OUT_MIN = range_min(DEF_OUT_W, DEF_SIGNED != 0);

    // Clamp a wide value into [min_v, max_v]
    function automatic sat_res_t clamp(input logic signed [63:0] v,
                                       input logic signed [63:0] max_v,
                                       input logic signed [63:0] min_v);
        sat_res_t r;
        r.value = v;
        r.sat   = 1'b0;
        if (v > max_v) begin
            r.value = max_v;
            r.sat   = 1'b1;
        end else if (v < min_v) begin
            r.value = min_v;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

    // Add two in-range values; the 64-bit sum cannot wrap for widths below 62
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input logic signed [63:0] max_v,
                                         input logic signed [63:0] min_v);
        return clamp(a + b, max_v, min_v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_acc_if
//  Description : Term-input and result-output handshake bundle of the
//                accumulator array. master = producer/consumer side,
//                slave = accumulator side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_acc_if
    import conv_acc_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*IN_W-1:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*OUT_W-1:0] out_data;
    logic [CHANNELS-1:0]       out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/conv_acc_lane.sv
`default_nettype none
// ============================================================================
//  Module      : conv_acc_lane
//  Description : One accumulator lane: operand extension, saturating
//                accumulate, optional ReLU and clamp to the output width.
//                The lane presents its window result combinationally; the
//                parent registers it on window completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_acc_lane
    import conv_acc_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SIGNED = DEF_SIGNED
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_relu_en,
    input  wire logic             i_add_en,
    input  wire logic             i_last,
    input  wire logic [IN_W-1:0]  i_term,
    output logic      [OUT_W-1:0] o_result,
    output logic                  o_sat
);
    localparam bit                 c_signed  = (SIGNED != 0);
    localparam logic signed [63:0] c_acc_max = range_max(ACC_W, c_signed);
    localparam logic signed [63:0] c_acc_min = range_min(ACC_W, c_signed);
    localparam logic signed [63:0] c_out_max = range_max(OUT_W, c_signed);
    localparam logic signed [63:0] c_out_min = range_min(OUT_W, c_signed);

    logic [ACC_W-1:0]   r_acc;
    logic               r_sat;
    logic signed [63:0] w_acc_ext;
    logic signed [63:0] w_term_ext;
    logic signed [63:0] w_final;
    sat_res_t           w_sum;
    sat_res_t           w_out;

    // Extend operands, add with saturation, then ReLU and clamp the result
    always_comb begin
        w_acc_ext  = {{(64-ACC_W){c_signed & r_acc[ACC_W-1]}}, r_acc};
        w_term_ext = {{(64-IN_W){c_signed & i_term[IN_W-1]}}, i_term};
        w_sum      = sat_add(w_acc_ext, w_term_ext, c_acc_max, c_acc_min);
        w_final    = w_sum.value;
        if (i_relu_en && c_signed && w_sum.value[63]) begin
            w_final = '0;
        end
        w_out      = clamp(w_final, c_out_max, c_out_min);
    end

    assign o_result = w_out.value[OUT_W-1:0];
    assign o_sat    = r_sat | w_sum.sat | w_out.sat;

    // Accumulator and sticky saturation flag; flush and completion restart the window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_flush) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_add_en) begin
            if (i_last) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end else begin
                r_acc <= w_sum.value[ACC_W-1:0];
                r_sat <= r_sat | w_sum.sat;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/conv_acc_array.sv
`default_nettype none
// ============================================================================
//  Module      : conv_acc_array
//  Description : Multi-channel windowed accumulator for convolution partial
//                products. Registered input stage, CHANNELS independent lanes,
//                one result word per TERMS-term window through a valid/ready
//                output register with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_acc_array
    import conv_acc_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int IN_W     = DEF_IN_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int TERMS    = DEF_TERMS,
    parameter int SIGNED   = DEF_SIGNED
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       flush,
    input  wire logic                       relu_en,
    output logic      [$clog2(TERMS)-1:0]   term_cnt,
    conv_acc_if.slave                       bus
);
    localparam int               CNT_W  = $clog2(TERMS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TERMS - 1);

    logic [CHANNELS*IN_W-1:0]  r_in_q;
    logic                      r_in_q_valid;
    logic [CNT_W-1:0]          r_term_cnt;
    logic                      r_out_valid;
    logic [CHANNELS*OUT_W-1:0] r_out_data;
    logic [CHANNELS-1:0]       r_out_sat;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_complete;
    logic [CHANNELS*OUT_W-1:0] w_result;
    logic [CHANNELS-1:0]       w_sat;

    // A new term may enter only when the output register can be freed in time
    assign w_in_ready = !flush && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_term_cnt == c_last);
    // Flush wins over a completion landing on the same edge
    assign w_complete = r_in_q_valid && w_last && !flush;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign term_cnt      = r_term_cnt;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
            conv_acc_lane #(
                .IN_W   (IN_W),
                .ACC_W  (ACC_W),
                .OUT_W  (OUT_W),
                .SIGNED (SIGNED)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_flush   (flush),
                .i_relu_en (relu_en),
                .i_add_en  (r_in_q_valid),
                .i_last    (w_last),
                .i_term    (r_in_q[c*IN_W +: IN_W]),
                .o_result  (w_result[c*OUT_W +: OUT_W]),
                .o_sat     (w_sat[c])
            );
        end
    endgenerate

    // Input stage: capture the accepted term; holds valid only for back-to-back accepts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_q       <= '0;
            r_in_q_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_q <= bus.in_data;
            end
            r_in_q_valid <= w_accept;
        end
    end

    // Window position: counts terms added, wraps on the last term of a window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_term_cnt <= '0;
        end else if (flush) begin
            r_term_cnt <= '0;
        end else if (r_in_q_valid) begin
            r_term_cnt <= w_last ? '0 : r_term_cnt + 1'b1;
        end
    end

    // Output register: load on completion, otherwise release on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_sat   <= w_sat;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_acc_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_acc_array
//  Description : Self-checking bench for conv_acc_array. A signed and an
//                unsigned build are instantiated; directed scenarios plus a
//                randomized run scored against a windowed-sum model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_acc_array;
    localparam int CH    = 4;
    localparam int IN_W  = 18;
    localparam int ACC_W = 24;
    localparam int OUT_W = 19;
    localparam int TERMS = 9;
    localparam int CNT_W = $clog2(TERMS);

    typedef struct {
        longint        v [CH];
        logic [CH-1:0] sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             relu_en;
    logic [CNT_W-1:0] term_cnt;
    logic [CNT_W-1:0] term_cnt_u;
    int               n_cmp = 0;
    int               n_bad = 0;
    exp_t             exp_q [$];

    conv_acc_if #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    conv_acc_if #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus_u ();

    conv_acc_array #(
        .CHANNELS(CH), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .TERMS(TERMS), .SIGNED(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .relu_en(relu_en),
        .term_cnt(term_cnt), .bus(bus.slave)
    );

    conv_acc_array #(
        .CHANNELS(CH), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .TERMS(TERMS), .SIGNED(0)
    ) dut_u (
        .clk(clk), .rst(rst), .flush(flush), .relu_en(relu_en),
        .term_cnt(term_cnt_u), .bus(bus_u.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decode one lane of a packed result vector
    function automatic longint lane_val(input logic [CH*OUT_W-1:0] d, input int c, input bit s);
        logic [OUT_W-1:0] f;
        f = d[c*OUT_W +: OUT_W];
        if (s && f[OUT_W-1]) return longint'(f) - (longint'(1) << OUT_W);
        return longint'(f);
    endfunction

    // Pack one value per lane into an input word
    function automatic logic [CH*IN_W-1:0] pack_in(input longint v [CH]);
        logic [CH*IN_W-1:0] d;
        logic [63:0]        x;
        d = '0;
        for (int c = 0; c < CH; c++) begin
            x = v[c];
            d[c*IN_W +: IN_W] = x[IN_W-1:0];
        end
        return d;
    endfunction

    // Reference: running sum clamped to the accumulator range, optional ReLU, output clamp
    function automatic void model(input longint t [TERMS], input bit s, input bit relu,
                                  output longint res, output bit sat);
        longint amax, amin, omax, omin, acc;
        amax = s ? (longint'(1) << (ACC_W-1)) - 1 : (longint'(1) << ACC_W) - 1;
        amin = s ? -(longint'(1) << (ACC_W-1)) : 0;
        omax = s ? (longint'(1) << (OUT_W-1)) - 1 : (longint'(1) << OUT_W) - 1;
        omin = s ? -(longint'(1) << (OUT_W-1)) : 0;
        acc = 0;
        sat = 1'b0;
        for (int i = 0; i < TERMS; i++) begin
            acc = acc + t[i];
            if (acc > amax) begin acc = amax; sat = 1'b1; end
            if (acc < amin) begin acc = amin; sat = 1'b1; end
        end
        if (relu && s && acc < 0) acc = 0;
        if (acc > omax) begin acc = omax; sat = 1'b1; end
        if (acc < omin) begin acc = omin; sat = 1'b1; end
        res = acc;
    endfunction

    // Offer one term on the signed instance; returns at the negedge after acceptance
    task automatic send_term(input logic [CH*IN_W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 500; k++) begin
            #1;
            if (bus.in_ready) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_cmp++; n_bad++;
        $display("FAIL send_term: in_ready stayed %0b for 500 cycles, required 1", bus.in_ready);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < CH; c++) bus.in_data[c*IN_W +: IN_W] = IN_W'($urandom);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %0b need 0", bus.out_valid); end
        n_cmp++; if (term_cnt !== '0) begin n_bad++; $display("FAIL reset term_cnt: got %0d need 0", term_cnt); end
        n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset out_data: got %h need 0", bus.out_data); end
        n_cmp++; if (bus.out_sat !== '0) begin n_bad++; $display("FAIL reset out_sat: got %b need 0", bus.out_sat); end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %0b need 1", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (term_cnt !== '0) begin n_bad++; $display("FAIL reset no-accept term_cnt: got %0d need 0", term_cnt); end
    endtask

    task automatic test_basic(input bit relu);
        longint v [CH];
        longint e;
        v = '{1000, -5, 0, 7};
        relu_en = relu;
        repeat (TERMS) send_term(pack_in(v));
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic early out_valid: got %0b need 0", bus.out_valid); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic latency out_valid: got %0b need 1", bus.out_valid); end
        for (int c = 0; c < CH; c++) begin
            e = v[c] * TERMS;
            if (relu && e < 0) e = 0;
            n_cmp++;
            if (lane_val(bus.out_data, c, 1'b1) !== e) begin
                n_bad++; $display("FAIL basic relu=%0b lane%0d: got %0d need %0d", relu, c, lane_val(bus.out_data, c, 1'b1), e);
            end
        end
        n_cmp++; if (bus.out_sat !== '0) begin n_bad++; $display("FAIL basic out_sat: got %b need 0", bus.out_sat); end
        @(negedge clk);
        relu_en = 1'b0;
    endtask

    task automatic test_saturation();
        longint v [CH];
        longint e [CH];
        v = '{131071, -131072, 0, 0};
        e = '{262143, -262144, 0, 0};
        repeat (TERMS) send_term(pack_in(v));
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL sat out_valid: got %0b need 1", bus.out_valid); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (lane_val(bus.out_data, c, 1'b1) !== e[c]) begin
                n_bad++; $display("FAIL sat lane%0d: got %0d need %0d", c, lane_val(bus.out_data, c, 1'b1), e[c]);
            end
        end
        n_cmp++; if (bus.out_sat !== 4'b0011) begin n_bad++; $display("FAIL sat flags: got %b need 0011", bus.out_sat); end
        @(negedge clk);
        // Unsigned build: all lanes at the 18-bit maximum
        bus_u.in_valid = 1'b1;
        bus_u.in_data  = {CH{18'h3FFFF}};
        repeat (TERMS) @(negedge clk);
        bus_u.in_valid = 1'b0;
        n_cmp++; if (bus_u.out_valid !== 1'b0) begin n_bad++; $display("FAIL usat early out_valid: got %0b need 0", bus_u.out_valid); end
        @(negedge clk);
        n_cmp++; if (bus_u.out_valid !== 1'b1) begin n_bad++; $display("FAIL usat out_valid: got %0b need 1", bus_u.out_valid); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (lane_val(bus_u.out_data, c, 1'b0) !== 524287) begin
                n_bad++; $display("FAIL usat lane%0d: got %0d need 524287", c, lane_val(bus_u.out_data, c, 1'b0));
            end
        end
        n_cmp++; if (bus_u.out_sat !== 4'b1111) begin n_bad++; $display("FAIL usat flags: got %b need 1111", bus_u.out_sat); end
        @(negedge clk);
        n_cmp++; if (term_cnt_u !== '0) begin n_bad++; $display("FAIL usat term_cnt: got %0d need 0", term_cnt_u); end
    endtask

    task automatic test_backpressure();
        longint v [CH];
        v = '{5, 5, 5, 5};
        bus.out_ready = 1'b0;
        repeat (TERMS) send_term(pack_in(v));
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp out_valid: got %0b need 1", bus.out_valid); end
        // Offer the next window's first term during the stall; it must not be taken
        v = '{2, 2, 2, 2};
        bus.in_valid = 1'b1;
        bus.in_data  = pack_in(v);
        for (int i = 0; i < 20; i++) begin
            #1;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp cyc%0d in_ready: got %0b need 0", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp cyc%0d out_valid: got %0b need 1", i, bus.out_valid); end
            for (int c = 0; c < CH; c++) begin
                n_cmp++;
                if (lane_val(bus.out_data, c, 1'b1) !== 45) begin
                    n_bad++; $display("FAIL bp cyc%0d lane%0d: got %0d need 45", i, c, lane_val(bus.out_data, c, 1'b1));
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (term_cnt !== '0) begin n_bad++; $display("FAIL bp stalled term_cnt: got %0d need 0", term_cnt); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp release out_valid: got %0b need 0", bus.out_valid); end
        repeat (TERMS-1) send_term(pack_in(v));
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp second out_valid: got %0b need 1", bus.out_valid); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (lane_val(bus.out_data, c, 1'b1) !== 18) begin
                n_bad++; $display("FAIL bp second lane%0d: got %0d need 18", c, lane_val(bus.out_data, c, 1'b1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        longint v [CH];
        v = '{500, 500, 500, 500};
        repeat (4) send_term(pack_in(v));
        flush = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush in_ready: got %0b need 0", bus.in_ready); end
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (term_cnt !== '0) begin n_bad++; $display("FAIL flush term_cnt: got %0d need 0", term_cnt); end
        v = '{10, 10, 10, 10};
        repeat (TERMS) send_term(pack_in(v));
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL flush window out_valid: got %0b need 1", bus.out_valid); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (lane_val(bus.out_data, c, 1'b1) !== 90) begin
                n_bad++; $display("FAIL flush window lane%0d: got %0d need 90", c, lane_val(bus.out_data, c, 1'b1));
            end
        end
        @(negedge clk);
        // Flush on the completion cycle suppresses the result
        v = '{7, 7, 7, 7};
        repeat (TERMS) send_term(pack_in(v));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush-completion out_valid: got %0b need 0", bus.out_valid); end
        n_cmp++; if (term_cnt !== '0) begin n_bad++; $display("FAIL flush-completion term_cnt: got %0d need 0", term_cnt); end
        // A pending result survives a flush
        bus.out_ready = 1'b0;
        v = '{4, 4, 4, 4};
        repeat (TERMS) send_term(pack_in(v));
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL flush-pending out_valid: got %0b need 1", bus.out_valid); end
        n_cmp++; if (lane_val(bus.out_data, 0, 1'b1) !== 36) begin n_bad++; $display("FAIL flush-pending lane0: got %0d need 36", lane_val(bus.out_data, 0, 1'b1)); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush-pending release: got %0b need 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        longint v [CH];
        v = '{100, 100, 100, 100};
        repeat (5) send_term(pack_in(v));
        n_cmp++; if (term_cnt !== CNT_W'(4)) begin n_bad++; $display("FAIL rstmid pre term_cnt: got %0d need 4", term_cnt); end
        #2; rst = 1'b0; #1;
        n_cmp++; if (term_cnt !== '0) begin n_bad++; $display("FAIL rstmid term_cnt: got %0d need 0", term_cnt); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid out_valid: got %0b need 0", bus.out_valid); end
        @(negedge clk);
        rst = 1'b1;
        // Reset while a result waits on backpressure
        bus.out_ready = 1'b0;
        v = '{3, 3, 3, 3};
        repeat (TERMS) send_term(pack_in(v));
        @(negedge clk);
        n_cmp++; if (lane_val(bus.out_data, 0, 1'b1) !== 27) begin n_bad++; $display("FAIL rstmid held lane0: got %0d need 27", lane_val(bus.out_data, 0, 1'b1)); end
        #2; rst = 1'b0; #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid held out_valid: got %0b need 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL rstmid held out_data: got %h need 0", bus.out_data); end
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        v = '{11, 11, 11, 11};
        repeat (TERMS) send_term(pack_in(v));
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid after out_valid: got %0b need 1", bus.out_valid); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (lane_val(bus.out_data, c, 1'b1) !== 99) begin
                n_bad++; $display("FAIL rstmid after lane%0d: got %0d need 99", c, lane_val(bus.out_data, c, 1'b1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int n_win);
        exp_q.delete();
        fork
            begin : drv
                for (int w = 0; w < n_win; w++) begin
                    longint col [TERMS];
                    longint t   [TERMS][CH];
                    longint r;
                    bit     s;
                    exp_t   e;
                    int     mode;
                    relu_en = ($urandom_range(0, 1) != 0);
                    for (int c = 0; c < CH; c++) begin
                        mode = $urandom_range(0, 2);
                        for (int k = 0; k < TERMS; k++) begin
                            if (mode == 0)      col[k] = longint'($urandom_range(0, 2000)) - 1000;
                            else if (mode == 1) col[k] = longint'($urandom_range(0, 262143)) - 131072;
                            else                col[k] = ($urandom_range(0, 1) != 0) ? 131071 : -131072;
                            t[k][c] = col[k];
                        end
                        model(col, 1'b1, relu_en, r, s);
                        e.v[c]   = r;
                        e.sat[c] = s;
                    end
                    exp_q.push_back(e);
                    for (int k = 0; k < TERMS; k++) begin
                        send_term(pack_in(t[k]));
                        if ($urandom_range(0, 3) == 0) @(negedge clk);
                    end
                    @(negedge clk);
                end
            end
            begin : mon
                int   got;
                exp_t e;
                got = 0;
                for (int cyc = 0; cyc < 20000 && got < n_win; cyc++) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    if (bus.out_valid && bus.out_ready) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++; $display("FAIL rand unexpected result: got out_valid 1 need no result");
                        end else begin
                            e = exp_q.pop_front();
                            for (int c = 0; c < CH; c++) begin
                                if (c > 0) n_cmp++;
                                if (lane_val(bus.out_data, c, 1'b1) !== e.v[c]) begin
                                    n_bad++; $display("FAIL rand win%0d lane%0d: got %0d need %0d", got, c, lane_val(bus.out_data, c, 1'b1), e.v[c]);
                                end
                            end
                            n_cmp++;
                            if (bus.out_sat !== e.sat) begin
                                n_bad++; $display("FAIL rand win%0d sat: got %b need %b", got, bus.out_sat, e.sat);
                            end
                        end
                        got++;
                    end
                end
                if (got < n_win) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rand timeout: got %0d results need %0d", got, n_win);
                end
                bus.out_ready = 1'b1;
            end
        join
        relu_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b0;
        flush           = 1'b0;
        relu_en         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b1;
        bus_u.in_valid  = 1'b0;
        bus_u.in_data   = '0;
        bus_u.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_saturation();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random(16);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
